reg_bus_master: RTL and testbench
=================================

Name: reg_bus_master

Overview:
Register-bus initiator that drives the regfile access bus (wr_en/rd_en/addr/write_data, read_data return) from a command stream. A host-side bridge (UART/SPI/test sequencer) feeds it WRITE, READ and POLL commands. Every command returns exactly one response carrying data and status. Sits between the host bridge and all regfile_* blocks, and is the only agent driving their access bus.

Parameters:
RD_LATENCY, 0, cycles between bus_rd_en assertion and the bus_read_data sample; bus_addr is held stable throughout.
POLL_GAP, 4, idle cycles between consecutive POLL reads.
POLL_MAX, 1024, maximum reads per POLL before timeout (≥1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=WRITE 1=READ 2=POLL 3=illegal
cmd_addr  in  14  register address
cmd_data  in  16  write data (WRITE) / expected value (POLL)
cmd_mask  in  16  POLL compare mask; ignored otherwise
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  16  read/last-poll data; 0 for WRITE/illegal
rsp_status  out  2  0=OK 1=TIMEOUT 2=ILLEGAL
bus_wr_en  out  1  single-cycle write strobe
bus_rd_en  out  1  read strobe
bus_addr  out  14  register address
bus_write_data  out  16  write data
bus_read_data  in  16  read data from regfile mux
busy  out  1  high in every state except IDLE

Behaviour:
- Single clock. Reset is synchronous and active-high: rst sampled high at a clk edge forces reset state at that edge. The team's ports are clk and rst.
- Reset values: cmd_ready=0 while rst high; all other outputs 0; state=IDLE. cmd_ready=1 in the first cycle after rst falls.
- States: IDLE, WR, RD, RDWAIT, GAP, RESP.
- IDLE: cmd_ready=1. Handshake at cycle T latches op/addr/data/mask. Next state: WR (op0), RD (op0/1/2 respectively WR, RD, RD), or RESP with status 2 (op3, no bus activity).
- WR (T+1): bus_wr_en=1 for exactly one cycle, with bus_addr/bus_write_data = latched values. Next state RESP with data 0, status 0.
- RD: bus_rd_en=1 for one cycle, bus_addr=latched addr.
  - RD_LATENCY=0: bus_read_data sampled in the same cycle.
  - RD_LATENCY=L>0: RDWAIT for L cycles with bus_addr held and rd_en low; sample in the last RDWAIT cycle.
  - READ: next state RESP with the sampled data, status 0.
- POLL: after each sample, compare (sample & mask) == (cmd_data & mask).
  - Match: RESP, status 0.
  - Else if reads == POLL_MAX: RESP, status 1, data = last sample.
  - Else: GAP for POLL_GAP cycles (strobes low), then RD. Read counter is clog2(POLL_MAX+1) bits and cleared on accept.
- RESP: rsp_valid=1; rsp_data and rsp_status are stable until rsp_ready. The handshake cycle is the last RESP cycle; the next cycle is IDLE. No new command is accepted and no bus strobe is issued while in RESP (backpressure).
- Timing: WRITE response at T+2. READ response at T+2+RD_LATENCY. Minimum command period is 3 cycles with rsp_ready tied high.
- bus_addr/bus_write_data hold their last driven value outside transactions. bus_wr_en and bus_rd_en are never high together.
- cmd_mask=0 on a POLL matches on the first read.
- rst during any state: at that edge, strobes drop, rsp_valid drops, the pending command is discarded without a response, and the block enters IDLE.
- cmd_valid without cmd_ready has no effect. Command inputs are don't-care when cmd_valid is low.

Test Plan:
- WRITE addr 0x000C data 0x1234, rsp_ready=1 → bus_wr_en high only at T+1 with bus_addr=0x000C and bus_write_data=0x1234; rsp at T+2 with data 0x0000, status 0; cmd_ready high at T+3.
- READ addr 0x0040, model returns 0xBEEF, RD_LATENCY=0 and RD_LATENCY=2 → one bus_rd_en pulse; rsp_data=0xBEEF at T+2 and T+4 respectively; bus_addr stable across RDWAIT.
- POLL addr 0x0041, mask 0x0001, data 0x0001; model sets bit0 before the 3rd read → exactly 3 rd_en pulses, 5 cycles apart; rsp data 0x0001, status 0.
- POLL POLL_MAX=8, model always returns 0x0000, mask 0x0002, data 0x0002 → exactly 8 rd_en pulses; rsp status 1, data 0x0000.
- Backpressure and illegal op:
  - rsp_ready low for 10 cycles after a READ → rsp_valid/data/status unchanged, cmd_ready=0, no strobes.
  - Then op 3 → rsp status 2 at T+1, no bus strobes.
- rst asserted for 1 cycle during the GAP of a POLL → next cycle all outputs 0 except cmd_ready=1; no response emitted; a following WRITE completes normally.

Source files
------------

// File: rtl/reg_bus_master.sv
// reg_bus_master: register-bus initiator between a host command bridge and
// the regfile_* access bus. Accepts WRITE/READ/POLL commands and returns
// exactly one response (data + status) per accepted command.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cmd_*            command stream (valid/ready, op, addr, data, mask)
//   rsp_*            response stream (valid/ready, data, status)
//   bus_*            regfile access bus (wr_en, rd_en, addr, write/read data)
//   busy             high whenever the FSM is not idle
module reg_bus_master #(
  parameter int unsigned RD_LATENCY = 0,
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned POLL_MAX   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [13:0] cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        bus_wr_en,
  output logic        bus_rd_en,
  output logic [13:0] bus_addr,
  output logic [15:0] bus_write_data,
  input  logic [15:0] bus_read_data,
  output logic        busy
);

  localparam int unsigned CNT_W    = $clog2(POLL_MAX + 1);
  localparam int unsigned WAIT_MAX = (RD_LATENCY > POLL_GAP) ? RD_LATENCY : POLL_GAP;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_RDWAIT, S_GAP, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0, OP_READ = 2'd1, OP_POLL = 2'd2, OP_ILLEGAL = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_OK = 2'd0, ST_TIMEOUT = 2'd1, ST_ILLEGAL = 2'd2
  } status_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [15:0]        exp_q, exp_d;
  logic [15:0]        mask_q, mask_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  status_t            rsp_status_q, rsp_status_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic [13:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               busy_q, busy_d;

  logic               sample;
  logic [CNT_W-1:0]   reads_now;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    exp_d        = exp_q;
    mask_d       = mask_q;
    rd_cnt_d     = rd_cnt_q;
    wait_d       = wait_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sample       = 1'b0;
    reads_now    = rd_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = op_t'(cmd_op);
          exp_d    = cmd_data;
          mask_d   = cmd_mask;
          rd_cnt_d = '0;
          unique case (op_t'(cmd_op))
            OP_WRITE: begin
              state_d = S_WR;
              addr_d  = cmd_addr;
              wdata_d = cmd_data;
            end
            OP_READ, OP_POLL: begin
              state_d = S_RD;
              addr_d  = cmd_addr;
            end
            default: begin
              state_d      = S_RESP;
              rsp_data_d   = '0;
              rsp_status_d = ST_ILLEGAL;
            end
          endcase
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        rsp_data_d   = '0;
        rsp_status_d = ST_OK;
      end
      S_RD: begin
        rd_cnt_d  = rd_cnt_q + 1'b1;
        reads_now = rd_cnt_d;
        if (RD_LATENCY == 0) begin
          sample = 1'b1;
        end else begin
          state_d = S_RDWAIT;
          wait_d  = WAIT_W'(RD_LATENCY - 1);
        end
      end
      S_RDWAIT: begin
        if (wait_q == '0) sample = 1'b1;
        else              wait_d = wait_q - 1'b1;
      end
      S_GAP: begin
        if (wait_q == '0) state_d = S_RD;
        else              wait_d  = wait_q - 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // reads_now already includes the read being sampled, so the timeout
    // fires on the POLL_MAX-th sample rather than one read later.
    if (sample) begin
      if (op_q != OP_POLL || ((bus_read_data ^ exp_q) & mask_q) == '0) begin
        state_d      = S_RESP;
        rsp_data_d   = bus_read_data;
        rsp_status_d = ST_OK;
      end else if (reads_now == CNT_W'(POLL_MAX)) begin
        state_d      = S_RESP;
        rsp_data_d   = bus_read_data;
        rsp_status_d = ST_TIMEOUT;
      end else if (POLL_GAP == 0) begin
        state_d = S_RD;
      end else begin
        state_d = S_GAP;
        wait_d  = WAIT_W'(POLL_GAP - 1);
      end
    end

    ready_d     = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    wr_en_d     = (state_d == S_WR);
    rd_en_d     = (state_d == S_RD);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_WRITE;
      exp_q        <= '0;
      mask_q       <= '0;
      rd_cnt_q     <= '0;
      wait_q       <= '0;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      exp_q        <= exp_d;
      mask_q       <= mask_d;
      rd_cnt_q     <= rd_cnt_d;
      wait_q       <= wait_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
    end
  end

  // ready_q is set by reset so cmd_ready rises in the first cycle after rst
  // falls; the rst gate keeps it low while reset is held.
  assign cmd_ready      = ready_q & ~rst;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_status     = rsp_status_q;
  assign bus_wr_en      = wr_en_q;
  assign bus_rd_en      = rd_en_q;
  assign bus_addr       = addr_q;
  assign bus_write_data = wdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: two instances (RD_LATENCY 0 and 2, POLL_GAP 4,
// POLL_MAX 8) share one command stream; each has its own bus model.
module tb_reg_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_valid, rsp_ready;
  logic [1:0]  cmd_op;
  logic [13:0] cmd_addr;
  logic [15:0] cmd_data, cmd_mask;

  logic        cmd_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data [2];
  logic [1:0]  rsp_status [2];
  logic        bus_wr_en [2];
  logic        bus_rd_en [2];
  logic [13:0] bus_addr [2];
  logic [15:0] bus_write_data [2];
  logic [15:0] bus_read_data [2];
  logic        busy [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  logic clr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  reg_bus_master #(.RD_LATENCY(0), .POLL_GAP(4), .POLL_MAX(8)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]),
    .rsp_status(rsp_status[0]), .bus_wr_en(bus_wr_en[0]), .bus_rd_en(bus_rd_en[0]),
    .bus_addr(bus_addr[0]), .bus_write_data(bus_write_data[0]),
    .bus_read_data(bus_read_data[0]), .busy(busy[0]));

  reg_bus_master #(.RD_LATENCY(2), .POLL_GAP(4), .POLL_MAX(8)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]),
    .rsp_status(rsp_status[1]), .bus_wr_en(bus_wr_en[1]), .bus_rd_en(bus_rd_en[1]),
    .bus_addr(bus_addr[1]), .bus_write_data(bus_write_data[1]),
    .bus_read_data(bus_read_data[1]), .busy(busy[1]));

  // Bus model: value depends on mode and on how many reads came before.
  function automatic logic [15:0] model_val(input int m, input int n);
    case (m)
      0:       return 16'hBEEF;
      1:       return (n >= 2) ? 16'h0001 : 16'h0000;
      3:       return 16'hA5C3;
      default: return 16'h0000;
    endcase
  endfunction

  int          rd_seen [2];
  logic [15:0] rd_hold [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        rd_seen[d] <= 0;
        rd_hold[d] <= '0;
      end else if (bus_rd_en[d]) begin
        rd_hold[d] <= model_val(mode, rd_seen[d]);
        rd_seen[d] <= rd_seen[d] + 1;
      end
    end
  end

  always_comb begin
    bus_read_data[0] = model_val(mode, rd_seen[0]);
    bus_read_data[1] = rd_hold[1];
  end

  // Monitor: per-instance event log, sampled on the falling edge.
  int          wr_n [2], rd_n [2], rsp_n [2], both_n [2], addr_chg [2];
  int          wr_cyc [2], first_rd [2], last_rd [2], rsp_cyc [2], rdy_cyc [2];
  logic [13:0] wr_addr [2], rd_addr [2], prev_addr [2];
  logic [15:0] wr_data [2], rsp_d [2];
  logic [1:0]  rsp_s [2];
  bit          got_rsp [2], got_rdy [2];
  logic        prev_busy [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        wr_n[d] <= 0; rd_n[d] <= 0; rsp_n[d] <= 0; both_n[d] <= 0; addr_chg[d] <= 0;
        got_rsp[d] <= 1'b0; got_rdy[d] <= 1'b0;
      end else begin
        if (bus_wr_en[d]) begin
          wr_n[d] <= wr_n[d] + 1; wr_cyc[d] <= cyc;
          wr_addr[d] <= bus_addr[d]; wr_data[d] <= bus_write_data[d];
        end
        if (bus_rd_en[d]) begin
          rd_n[d] <= rd_n[d] + 1;
          if (rd_n[d] == 0) first_rd[d] <= cyc;
          last_rd[d] <= cyc; rd_addr[d] <= bus_addr[d];
        end
        if (rsp_valid[d]) begin
          rsp_n[d] <= rsp_n[d] + 1;
          if (!got_rsp[d]) begin
            got_rsp[d] <= 1'b1; rsp_cyc[d] <= cyc;
            rsp_d[d] <= rsp_data[d]; rsp_s[d] <= rsp_status[d];
          end
        end
        if (got_rsp[d] && !got_rdy[d] && cmd_ready[d]) begin
          got_rdy[d] <= 1'b1; rdy_cyc[d] <= cyc;
        end
        if (bus_wr_en[d] && bus_rd_en[d]) both_n[d] <= both_n[d] + 1;
        if (busy[d] && prev_busy[d] && bus_addr[d] != prev_addr[d])
          addr_chg[d] <= addr_chg[d] + 1;
      end
      prev_busy[d] <= busy[d];
      prev_addr[d] <= bus_addr[d];
    end
  end

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [13:0] a, input logic [15:0] dt,
                       input logic [15:0] mk, output int t);
    int n = 0;
    @(negedge clk);
    while (!(cmd_ready[0] && cmd_ready[1]) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("issue_wait_ready", 0, 32'(n < 100), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = dt; cmd_mask = mk;
    t = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 14'($urandom); cmd_data = 16'($urandom);
  endtask

  task automatic wait_done(input int bound, input bit need_rdy);
    int n = 0;
    while (!(got_rsp[0] && got_rsp[1] && (!need_rdy || (got_rdy[0] && got_rdy[1])))
           && n < bound) begin
      @(negedge clk); #1; n++;
    end
    chk("wait_response", 0, 32'(n < bound), 32'd1);
  endtask

  task automatic check_outputs(input string tag, input logic exp_ready);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_cmd_ready"}, d, 32'(cmd_ready[d]), 32'(exp_ready));
      chk({tag, "_rsp"}, d, 32'({rsp_valid[d], rsp_status[d], rsp_data[d]}), 32'd0);
      chk({tag, "_strobes_busy"}, d, 32'({bus_wr_en[d], bus_rd_en[d], busy[d]}), 32'd0);
      chk({tag, "_bus"}, d, 32'({bus_addr[d], bus_write_data[d]}), 32'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [13:0] addr;
    logic [15:0] data;
    logic [15:0] mask;
    int          mode;
    logic [15:0] exp_data;
    logic [1:0]  exp_st;
    int          lat0, lat2, n_rd, n_wr, span0, span2;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic run_vec(input vec_t v, input int idx);
    int t;
    int lat [2];
    int span [2];
    string p;
    lat[0] = v.lat0;  lat[1] = v.lat2;
    span[0] = v.span0; span[1] = v.span2;
    p = $sformatf("v%0d", idx);
    mode = v.mode;
    clear_mon();
    issue(v.op, v.addr, v.data, v.mask, t);
    wait_done(120, 1'b1);
    for (int d = 0; d < 2; d++) begin
      chk({p, "_rsp_latency"}, d, 32'(rsp_cyc[d] - t), 32'(lat[d]));
      chk({p, "_rsp_data"}, d, 32'(rsp_d[d]), 32'(v.exp_data));
      chk({p, "_rsp_status"}, d, 32'(rsp_s[d]), 32'(v.exp_st));
      chk({p, "_rsp_cycles"}, d, 32'(rsp_n[d]), 32'd1);
      chk({p, "_ready_after_rsp"}, d, 32'(rdy_cyc[d] - rsp_cyc[d]), 32'd1);
      chk({p, "_rd_pulses"}, d, 32'(rd_n[d]), 32'(v.n_rd));
      chk({p, "_wr_pulses"}, d, 32'(wr_n[d]), 32'(v.n_wr));
      chk({p, "_wr_rd_overlap"}, d, 32'(both_n[d]), 32'd0);
      chk({p, "_addr_stable"}, d, 32'(addr_chg[d]), 32'd0);
      if (v.n_wr > 0) begin
        chk({p, "_wr_cycle"}, d, 32'(wr_cyc[d] - t), 32'd1);
        chk({p, "_wr_addr_data"}, d, 32'({wr_addr[d], wr_data[d]}), 32'({v.addr, v.data}));
      end
      if (v.n_rd > 0) begin
        chk({p, "_rd_addr"}, d, 32'(rd_addr[d]), 32'(v.addr));
        chk({p, "_first_rd"}, d, 32'(first_rd[d] - t), 32'd1);
        chk({p, "_rd_span"}, d, 32'(last_rd[d] - first_rd[d]), 32'(span[d]));
      end
    end
  endtask

  initial begin
    int t;
    int bp_err [2];
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b1;

    //          op     addr      data      mask     mode exp_data  st   lat0 lat2 rd wr span0 span2
    vecs[0] = '{2'd0, 14'h000C, 16'h1234, 16'h0000, 0, 16'h0000, 2'd0, 2,   2,  0, 1, 0,  0};
    vecs[1] = '{2'd1, 14'h0040, 16'h0000, 16'h0000, 0, 16'hBEEF, 2'd0, 2,   4,  1, 0, 0,  0};
    vecs[2] = '{2'd2, 14'h0041, 16'h0001, 16'h0001, 1, 16'h0001, 2'd0, 12,  18, 3, 0, 10, 14};
    vecs[3] = '{2'd2, 14'h0042, 16'h0002, 16'h0002, 2, 16'h0000, 2'd1, 37,  53, 8, 0, 35, 49};
    vecs[4] = '{2'd3, 14'h1FFF, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 2'd2, 1,   1,  0, 0, 0,  0};
    vecs[5] = '{2'd2, 14'h0100, 16'h5555, 16'h0000, 2, 16'h0000, 2'd0, 2,   4,  1, 0, 0,  0};
    vecs[6] = '{2'd1, 14'h3FFF, 16'h0000, 16'h0000, 3, 16'hA5C3, 2'd0, 2,   4,  1, 0, 0,  0};
    vecs[7] = '{2'd0, 14'h3FFF, 16'hFFFF, 16'h0000, 0, 16'h0000, 2'd0, 2,   2,  0, 1, 0,  0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset_held", 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_outputs("reset_release", 1'b1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Backpressure: response must hold while rsp_ready is low.
    mode = 0;
    clear_mon();
    rsp_ready = 1'b0;
    issue(2'd1, 14'h0040, 16'h0000, 16'h0000, t);
    wait_done(60, 1'b0);
    bp_err[0] = 0; bp_err[1] = 0;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (!(rsp_valid[d] && rsp_data[d] == 16'hBEEF && rsp_status[d] == 2'd0 &&
              !cmd_ready[d] && !bus_wr_en[d] && !bus_rd_en[d]))
          bp_err[d]++;
    end
    for (int d = 0; d < 2; d++) begin
      chk("bp_hold_cycles_bad", d, 32'(bp_err[d]), 32'd0);
      chk("bp_rd_pulses", d, 32'(rd_n[d]), 32'd1);
    end
    rsp_ready = 1'b1;
    run_vec(vecs[4], 40);

    // Reset during the GAP of a POLL: no response, clean idle, then a WRITE.
    mode = 2;
    clear_mon();
    issue(2'd2, 14'h0042, 16'h0002, 16'h0002, t);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs("mid_reset", 1'b1);
    repeat (20) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("mid_reset_no_rsp", d, 32'(rsp_n[d]), 32'd0);
    run_vec(vecs[0], 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
